// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths and opcode encodings for the alu32 datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 3;
    localparam int SHAMT_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_MUL = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_OR  = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_comb.sv
// ============================================================================
// Module      : alu_comb
// Description : Combinational function unit: (A, B, op) -> R, unsigned wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_comb
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [OP_W-1:0]   i_op,
    output logic [DATA_W-1:0] o_r
);

    logic [SHAMT_W-1:0] w_shamt;

    // Only the low five bits of B steer the shifter; upper bits are ignored.
    assign w_shamt = i_b[SHAMT_W-1:0];

    always_comb begin
        o_r = '0;
        case (i_op)
            OP_ADD: o_r = i_a + i_b;
            OP_SUB: o_r = i_a - i_b;
            OP_MUL: o_r = i_a * i_b;
            OP_AND: o_r = i_a & i_b;
            OP_XOR: o_r = i_a ^ i_b;
            OP_OR:  o_r = i_a | i_b;
            OP_SHL: o_r = i_a << w_shamt;
            OP_SHR: o_r = i_a >> w_shamt;
        endcase
    end

endmodule : alu_comb

`default_nettype wire

// File: rtl/alu32.sv
// ============================================================================
// Module      : alu32
// Description : Registered 32-bit ALU; result appears on O one clock later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu32
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   OPERATIONCODE,
    output logic [DATA_W-1:0] O
);

    logic [DATA_W-1:0] w_alu_r;
    logic [DATA_W-1:0] w_result_d;
    logic [DATA_W-1:0] r_result_q;

    alu_comb u_alu_comb (
        .i_a  (A),
        .i_b  (B),
        .i_op (OPERATIONCODE),
        .o_r  (w_alu_r)
    );

    always_comb begin
        w_result_d = w_alu_r;
    end

    // Asynchronous clear drops any in-flight result the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_q <= '0;
        end else begin
            r_result_q <= w_result_d;
        end
    end

    assign O = r_result_q;

endmodule : alu32

`default_nettype wire

// File: tb/tb_alu32.sv
// ============================================================================
// Module      : tb_alu32
// Description : Self-checking bench for alu32: vector table, scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp;
        string       name;
    } vec_t;

    localparam int N_VEC = 14;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  OPERATIONCODE;
    logic [31:0] O;

    int unsigned total;
    int unsigned bad;
    logic [31:0] sb_q[$];
    vec_t        vecs[N_VEC];

    alu32 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .A             (A),
        .B             (B),
        .OPERATIONCODE (OPERATIONCODE),
        .O             (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
        logic [63:0] prod;
        logic [4:0]  sh;
        prod = {32'h0, a} * {32'h0, b};
        sh   = b[4:0];
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return prod[31:0];
            3'd3:    return a & b;
            3'd4:    return a ^ b;
            3'd5:    return a | b;
            3'd6:    return a << sh;
            default: return a >> sh;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, capture on the rising edge, compare 1 ns later.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] exp, input string name);
        @(negedge clk);
        A = a;
        B = b;
        OPERATIONCODE = op;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            check(name, O, sb_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{32'hA3BB7473, 32'h2C52E2D8, 3'b101, 32'hAFFBF6FB, "or_1"};
        vecs[1]  = '{32'hE8A0B82B, 32'h0283B36C, 3'b101, 32'hEAA3BB6F, "or_2"};
        vecs[2]  = '{32'hFFFFFFFF, 32'h00000002, 3'b000, 32'h00000001, "add_wrap"};
        vecs[3]  = '{32'h12345678, 32'h11111111, 3'b000, 32'h23456789, "add"};
        vecs[4]  = '{32'h00000000, 32'h00000001, 3'b001, 32'hFFFFFFFF, "sub_wrap"};
        vecs[5]  = '{32'h00000005, 32'h00000003, 3'b001, 32'h00000002, "sub"};
        vecs[6]  = '{32'h00010000, 32'h00010001, 3'b010, 32'h00010000, "mul_trunc"};
        vecs[7]  = '{32'h0000FFFF, 32'h0000FFFF, 3'b010, 32'hFFFE0001, "mul"};
        vecs[8]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b011, 32'hF000F000, "and"};
        vecs[9]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'h0FF00FF0, "xor"};
        vecs[10] = '{32'h00000001, 32'h0000003F, 3'b110, 32'h80000000, "shl_31"};
        vecs[11] = '{32'h12345678, 32'hFFFFFFE0, 3'b110, 32'h12345678, "shl_0"};
        vecs[12] = '{32'h80000000, 32'h00000004, 3'b111, 32'h08000000, "shr_4"};
        vecs[13] = '{32'h80000000, 32'h0000001F, 3'b111, 32'h00000001, "shr_31"};

        rst_n = 1'b0;
        A = 32'h0;
        B = 32'h0;
        OPERATIONCODE = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", O, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].name);
        end

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [2:0]  rop;
            ra  = $urandom;
            rb  = $urandom;
            rop = 3'($urandom_range(0, 7));
            apply(ra, rb, rop, model(ra, rb, rop), "random");
        end

        // Opcode change between edges must not reach O until the next edge.
        apply(32'h00000001, 32'h00000002, 3'b000, 32'h00000003, "lat_add");
        #2;
        OPERATIONCODE = 3'b001;
        #1;
        check("lat_hold", O, 32'h00000003);
        @(posedge clk);
        #1;
        check("lat_update", O, 32'hFFFFFFFF);

        // Reset asserted mid-cycle clears O without a clock edge.
        apply(32'hDEADBEEF, 32'h00000000, 3'b101, 32'hDEADBEEF, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", O, 32'h0);
        @(posedge clk);
        #1;
        check("reset_hold_edge", O, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", O, 32'h0);
        @(posedge clk);
        #1;
        check("post_reset_capture", O, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu32

`default_nettype wire
